// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the idle instruction word and the
// fetch sequencer state encoding used by the RTL and the bench.
package cpu_pkg;

  localparam logic [3:0]  OP_ALU      = 4'b0000;
  localparam logic [3:0]  OP_ALUI     = 4'b0001;
  localparam logic [3:0]  HALT_OP     = 4'b1110;
  localparam logic [3:0]  OP_IDLE     = 4'b1111;
  localparam logic [15:0] IDLE_WORD   = {OP_IDLE, 12'h000};

  localparam logic [7:0]  MEM_TIMEOUT  = 8'd8;
  localparam logic [7:0]  EXEC_TIMEOUT = 8'd64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_READ = 3'd2,
    ST_LOAD = 3'd3,
    ST_EXEC = 3'd4,
    ST_HALT = 3'd5
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] ir);
    return ir[15:12] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating 8-bit wait counter; o_expired flags the last permitted wait cycle
// (count == limit-1) so the caller can bail out on that same cycle.
module fetch_timeout_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_limit,
  output logic       o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == (i_limit - 8'd1));

endmodule

// File: rtl/instr_fetch_fsm.sv
// Fetch/dispatch sequencer: fetches one instruction word into the IR, presents
// it to the execution FSMs until they signal done, and drives IDLE_WORD otherwise.
module instr_fetch_fsm
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] bus_in,
  input  logic        mem_ready,
  input  logic        exec_done,
  output logic        pcOutEN,
  output logic        marIn,
  output logic        memRead,
  output logic        mdrOutEN,
  output logic [15:0] instruction,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired_count
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [15:0]  r_ir;
  logic [15:0]  r_retired;
  logic         r_fault;
  logic         w_retire;
  logic         w_timeout;
  logic         w_expired;
  logic         w_ctr_en;
  logic [7:0]   w_limit;

  // Counter runs only while waiting; any other state clears it, so both
  // READ and EXEC start their wait from zero.
  assign w_ctr_en = (r_state == ST_READ) || (r_state == ST_EXEC);
  assign w_limit  = (r_state == ST_READ) ? MEM_TIMEOUT : EXEC_TIMEOUT;

  fetch_timeout_ctr u_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_ctr_en),
    .i_en      (w_ctr_en),
    .i_limit   (w_limit),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ir      <= 16'h0000;
      r_retired <= 16'h0000;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_LOAD) begin
        r_ir <= bus_in;
      end
      if (w_retire) begin
        r_retired <= r_retired + 16'd1;
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: if (run) w_next_state = ST_ADDR;
      ST_ADDR: w_next_state = ST_READ;
      ST_READ: begin
        if (mem_ready) begin
          w_next_state = ST_LOAD;
        end else if (w_expired) begin
          w_next_state = ST_HALT;
          w_timeout    = 1'b1;
        end
      end
      ST_LOAD: w_next_state = ST_EXEC;
      ST_EXEC: begin
        // HALT needs no execution FSM, so it retires without waiting for done.
        if (is_halt(r_ir)) begin
          w_next_state = ST_HALT;
          w_retire     = 1'b1;
        end else if (exec_done) begin
          w_next_state = run ? ST_ADDR : ST_IDLE;
          w_retire     = 1'b1;
        end else if (w_expired) begin
          w_next_state = ST_HALT;
          w_timeout    = 1'b1;
        end
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign pcOutEN       = (r_state == ST_ADDR);
  assign marIn         = (r_state == ST_ADDR);
  assign memRead       = (r_state == ST_READ) || (r_state == ST_LOAD);
  assign mdrOutEN      = (r_state == ST_LOAD);
  assign instruction   = (r_state == ST_EXEC) ? r_ir : IDLE_WORD;
  assign halted        = (r_state == ST_HALT);
  assign fault         = r_fault;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_instr_fetch_fsm.sv
// Directed bench for instr_fetch_fsm: fetch timing, back-to-back words, HALT,
// memory/exec timeouts and asynchronous reset, with hand-computed expectations.
module tb_instr_fetch_fsm;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] bus_in;
  logic        mem_ready;
  logic        exec_done;
  logic        pcOutEN;
  logic        marIn;
  logic        memRead;
  logic        mdrOutEN;
  logic [15:0] instruction;
  logic        halted;
  logic        fault;
  logic [15:0] retired_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .bus_in        (bus_in),
    .mem_ready     (mem_ready),
    .exec_done     (exec_done),
    .pcOutEN       (pcOutEN),
    .marIn         (marIn),
    .memRead       (memRead),
    .mdrOutEN      (mdrOutEN),
    .instruction   (instruction),
    .halted        (halted),
    .fault         (fault),
    .retired_count (retired_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input fetch_state_t exp);
    chk(tag, 16'(dut.r_state), 16'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // From IDLE with run=1 and mem_ready=1: ADDR, READ, LOAD, then EXEC entry.
  task automatic fetch_to_exec(input string tag);
    tick();
    chk_state({tag, "_addr"}, ST_ADDR);
    chk({tag, "_strobe_addr"}, {12'h0, pcOutEN, marIn, memRead, mdrOutEN}, 16'h000C);
    tick();
    chk_state({tag, "_read"}, ST_READ);
    tick();
    chk_state({tag, "_load"}, ST_LOAD);
    chk({tag, "_strobe_load"}, {12'h0, pcOutEN, marIn, memRead, mdrOutEN}, 16'h0003);
    tick();
    chk_state({tag, "_exec"}, ST_EXEC);
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; bus_in = 16'h0000; mem_ready = 1'b0; exec_done = 1'b0;
    tick();
    tick();
    chk_state("rst_state", ST_IDLE);
    chk("rst_instr", instruction, 16'hF000);
    chk("rst_flags", {14'h0, halted, fault}, 16'h0000);
    chk("rst_strobes", {12'h0, pcOutEN, marIn, memRead, mdrOutEN}, 16'h0000);
    chk("rst_retired", retired_count, 16'h0000);
    chk("rst_ir", dut.r_ir, 16'h0000);
    rst = 1'b1;

    // Single instruction, done pulsed 9 cycles after EXEC entry.
    run = 1'b1; mem_ready = 1'b1; bus_in = 16'h1045;
    fetch_to_exec("t1");
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t1_instr_c%0d", i), instruction, 16'h1045);
      tick();
    end
    chk("t1_instr_c9", instruction, 16'h1045);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("t1_instr_after", instruction, 16'hF000);
    chk("t1_retired", retired_count, 16'd1);
    chk_state("t1_back_addr", ST_ADDR);

    // Second identical word: idle gap already shown above; complete it.
    tick(); tick(); tick();
    chk("t2_instr", instruction, 16'h1045);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("t2_gap", instruction, 16'hF000);
    chk("t2_retired", retired_count, 16'd2);

    // run drops in ADDR: the fetch completes, then the sequencer parks in IDLE.
    run = 1'b0;
    tick(); tick(); tick();
    chk_state("t2_run0_exec", ST_EXEC);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk_state("t2_run0_idle", ST_IDLE);
    chk("t2_run0_retired", retired_count, 16'd3);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("t2_stray_done", retired_count, 16'd3);

    // HALT opcode.
    do_reset();
    run = 1'b1; bus_in = 16'hE000;
    fetch_to_exec("t3");
    chk("t3_instr", instruction, 16'hE000);
    tick();
    chk("t3_flags", {14'h0, halted, fault}, 16'h0002);
    chk("t3_retired", retired_count, 16'd1);
    chk("t3_instr_idle", instruction, 16'hF000);
    run = 1'b0; tick();
    run = 1'b1; tick(); tick();
    chk_state("t3_stays_halt", ST_HALT);
    chk("t3_strobes", {12'h0, pcOutEN, marIn, memRead, mdrOutEN}, 16'h0000);

    // Memory never ready: 8 READ cycles then HALT with fault.
    do_reset();
    run = 1'b1; mem_ready = 1'b0; bus_in = 16'h1045;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_read_c%0d", i), {13'h0, dut.r_state}, 16'(ST_READ));
      tick();
    end
    chk("t4_flags", {14'h0, halted, fault}, 16'h0003);
    chk("t4_memread", {15'h0, memRead}, 16'h0000);
    mem_ready = 1'b1;
    tick();
    chk_state("t4_ready_ignored", ST_HALT);

    // exec_done never arrives: 64 EXEC cycles then HALT with fault.
    do_reset();
    run = 1'b1; mem_ready = 1'b1; bus_in = 16'h0123;
    fetch_to_exec("t5");
    for (int i = 0; i < 64; i++) begin
      if (dut.r_state !== ST_EXEC) begin
        chk($sformatf("t5_exec_c%0d", i), 16'(dut.r_state), 16'(ST_EXEC));
        break;
      end
      tick();
    end
    chk("t5_flags", {14'h0, halted, fault}, 16'h0003);
    chk("t5_retired", retired_count, 16'd0);

    // Asynchronous reset mid-EXEC after one retired instruction.
    do_reset();
    run = 1'b1; bus_in = 16'h1045;
    fetch_to_exec("t6a");
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    tick(); tick(); tick();
    chk_state("t6_exec", ST_EXEC);
    tick(); tick();
    chk("t6_retired_before", retired_count, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_state("t6_async_idle", ST_IDLE);
    chk("t6_instr", instruction, 16'hF000);
    chk("t6_retired", retired_count, 16'd0);
    chk("t6_ctr", {8'h0, dut.u_ctr.r_count}, 16'h0000);
    chk("t6_flags", {14'h0, halted, fault}, 16'h0000);
    tick();
    rst = 1'b1;
    run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
